// File: rtl/enc_scan_arbiter.sv
// enc_scan_arbiter: one time-shared quadrature decoder serving NUM_ENC rotary
// encoders. A scan pointer visits one channel per cycle. Each channel keeps a
// wrapping detent position, a 3-bit sub-count, a pending-event flag and sticky
// err/ovf flags. A round-robin arbiter feeds pending events into a single
// valid/ready output register.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   enc_a, enc_b     raw encoder pins (async, idle high), per channel
//   clr              per-channel synchronous clear
//   ev_valid/ready   event handshake; ev_chan/ev_dir/ev_pos are the payload
//   pos_flat         live positions, channel i at [i*POS_W +: POS_W]
//   err, ovf         sticky illegal-transition / overwritten-event flags
module enc_scan_arbiter #(
    parameter int unsigned NUM_ENC = 4,
    parameter int unsigned MAX_POS = 19,
    parameter int unsigned POS_W   = 5,
    parameter int unsigned CH_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_ENC-1:0]       enc_a,
    input  logic [NUM_ENC-1:0]       enc_b,
    input  logic [NUM_ENC-1:0]       clr,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [CH_W-1:0]          ev_chan,
    output logic                     ev_dir,
    output logic [POS_W-1:0]         ev_pos,
    output logic [NUM_ENC*POS_W-1:0] pos_flat,
    output logic [NUM_ENC-1:0]       err,
    output logic [NUM_ENC-1:0]       ovf
);

    localparam logic [1:0] AB_IDLE = 2'b11;

    // Position of an AB code in the forward sequence 11->10->00->01.
    function automatic logic [1:0] gidx(input logic [1:0] ab);
        case (ab)
            2'b11:   gidx = 2'd0;
            2'b10:   gidx = 2'd1;
            2'b00:   gidx = 2'd2;
            default: gidx = 2'd3;
        endcase
    endfunction

    logic [NUM_ENC-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [CH_W-1:0]    scan_q, scan_d;
    logic [1:0]         ab_q   [NUM_ENC];
    logic [1:0]         ab_d   [NUM_ENC];
    logic signed [2:0]  sub_q  [NUM_ENC];
    logic signed [2:0]  sub_d  [NUM_ENC];
    logic [POS_W-1:0]   pos_q  [NUM_ENC];
    logic [POS_W-1:0]   pos_d  [NUM_ENC];
    logic [NUM_ENC-1:0] pend_q, pend_d, pdir_q, pdir_d;
    logic [NUM_ENC-1:0] err_q, err_d, ovf_q, ovf_d;
    logic               ev_valid_q, ev_valid_d, ev_dir_q, ev_dir_d;
    logic [CH_W-1:0]    ev_chan_q, ev_chan_d, last_q, last_d;
    logic [POS_W-1:0]   ev_pos_q, ev_pos_d;

    logic [CH_W-1:0]    cand, grant_ch;
    logic               found, grant_fire, ev_fire, ev_dir_new;
    logic [1:0]         new_ab, old_ab, step;
    logic signed [3:0]  sub_ext, sub_sum;

    // Two-flop synchronisers on every pin; reset to the idle-high level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1_q <= '1;
            a_s2_q <= '1;
            b_s1_q <= '1;
            b_s2_q <= '1;
        end else begin
            a_s1_q <= enc_a;
            a_s2_q <= a_s1_q;
            b_s1_q <= enc_b;
            b_s2_q <= b_s1_q;
        end
    end

    // Per-channel and output state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_ENC); i++) begin
                ab_q[i]  <= AB_IDLE;
                sub_q[i] <= '0;
                pos_q[i] <= '0;
            end
            scan_q     <= '0;
            pend_q     <= '0;
            pdir_q     <= '0;
            err_q      <= '0;
            ovf_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_chan_q  <= '0;
            ev_dir_q   <= 1'b0;
            ev_pos_q   <= '0;
            last_q     <= CH_W'(NUM_ENC - 1);
        end else begin
            for (int i = 0; i < int'(NUM_ENC); i++) begin
                ab_q[i]  <= ab_d[i];
                sub_q[i] <= sub_d[i];
                pos_q[i] <= pos_d[i];
            end
            scan_q     <= scan_d;
            pend_q     <= pend_d;
            pdir_q     <= pdir_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            ev_valid_q <= ev_valid_d;
            ev_chan_q  <= ev_chan_d;
            ev_dir_q   <= ev_dir_d;
            ev_pos_q   <= ev_pos_d;
            last_q     <= last_d;
        end
    end

    // Arbitration, decode of the scanned channel, then clears (clr has the last word).
    always_comb begin
        ab_d       = ab_q;
        sub_d      = sub_q;
        pos_d      = pos_q;
        pend_d     = pend_q;
        pdir_d     = pdir_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        ev_valid_d = ev_valid_q;
        ev_chan_d  = ev_chan_q;
        ev_dir_d   = ev_dir_q;
        ev_pos_d   = ev_pos_q;
        last_d     = last_q;
        scan_d     = (scan_q == CH_W'(NUM_ENC - 1)) ? '0 : scan_q + CH_W'(1);
        cand       = '0;
        found      = 1'b0;
        grant_ch   = '0;
        grant_fire = 1'b0;
        ev_fire    = 1'b0;
        ev_dir_new = 1'b0;

        // Round-robin search starting just after the last grant.
        for (int k = 1; k <= int'(NUM_ENC); k++) begin
            cand = CH_W'((int'(last_q) + k) % int'(NUM_ENC));
            if (!found && pend_q[cand]) begin
                found    = 1'b1;
                grant_ch = cand;
            end
        end

        if (!ev_valid_q || ev_ready) begin
            ev_valid_d = found;
            if (found) begin
                grant_fire       = 1'b1;
                ev_chan_d        = grant_ch;
                ev_dir_d         = pdir_q[grant_ch];
                ev_pos_d         = pos_q[grant_ch];
                last_d           = grant_ch;
                pend_d[grant_ch] = 1'b0;
            end
        end

        new_ab  = {a_s2_q[scan_q], b_s2_q[scan_q]};
        old_ab  = ab_q[scan_q];
        step    = gidx(new_ab) - gidx(old_ab);
        sub_ext = {sub_q[scan_q][2], sub_q[scan_q]};
        case (step)
            2'd1:    sub_sum = sub_ext + 4'sd1;
            2'd3:    sub_sum = sub_ext - 4'sd1;
            default: sub_sum = sub_ext;
        endcase

        // A step of 2 means both pins flipped between samples.
        if (step == 2'd2) begin
            err_d[scan_q] = 1'b1;
            sub_d[scan_q] = '0;
        end else if (step != 2'd0) begin
            if (new_ab == AB_IDLE) begin
                sub_d[scan_q] = '0;
                if (sub_sum == 4'sd4) begin
                    ev_fire       = 1'b1;
                    ev_dir_new    = 1'b1;
                    pos_d[scan_q] = (pos_q[scan_q] == POS_W'(MAX_POS)) ? '0
                                    : pos_q[scan_q] + POS_W'(1);
                end else if (sub_sum == -4'sd4) begin
                    ev_fire       = 1'b1;
                    ev_dir_new    = 1'b0;
                    pos_d[scan_q] = (pos_q[scan_q] == '0) ? POS_W'(MAX_POS)
                                    : pos_q[scan_q] - POS_W'(1);
                end
            end else begin
                sub_d[scan_q] = sub_sum[2:0];
            end
        end
        ab_d[scan_q] = new_ab;

        // A pending event being granted this cycle is delivered, not overwritten.
        if (ev_fire) begin
            if (pend_q[scan_q] && !(grant_fire && grant_ch == scan_q)) begin
                ovf_d[scan_q] = 1'b1;
            end
            pend_d[scan_q] = 1'b1;
            pdir_d[scan_q] = ev_dir_new;
        end

        for (int i = 0; i < int'(NUM_ENC); i++) begin
            if (clr[i]) begin
                pos_d[i]  = '0;
                sub_d[i]  = '0;
                pend_d[i] = 1'b0;
                err_d[i]  = 1'b0;
                ovf_d[i]  = 1'b0;
                ab_d[i]   = {a_s2_q[i], b_s2_q[i]};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_ENC); i++) begin
            pos_flat[i*POS_W +: POS_W] = pos_q[i];
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_chan  = ev_chan_q;
    assign ev_dir   = ev_dir_q;
    assign ev_pos   = ev_pos_q;
    assign err      = err_q;
    assign ovf      = ovf_q;

endmodule
